// File: rtl/sdram_mport_pkg.sv
// Shared definitions for the multi-port SDRAM front end: FSM encoding,
// port-count limit, data width and index-width helper.
package sdram_mport_pkg;

  localparam int unsigned NPORT_MAX = 8;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 1) return $unsigned($clog2(n));
    return 1;
  endfunction

endpackage

// File: rtl/sdram_mport_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr.
module sdram_mport_rr_arbiter
  import sdram_mport_pkg::*;
#(
  parameter int unsigned NPORT = 2,
  parameter int unsigned IW    = idx_width(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= NPORT) s = s - NPORT;
    return IW'(s);
  endfunction

  logic [IW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      k = wrap(ptr, i);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/sdram_mport.sv
// Multi-port front end for sdram_top: round-robin grant, DQM latch,
// parametrised ack delay and controller reset stretcher.
module sdram_mport
  import sdram_mport_pkg::*;
#(
  parameter int unsigned NPORT   = 2,
  parameter int unsigned AW      = 21,
  parameter int unsigned ACK_DLY = 2,
  parameter int unsigned RST_DLY = 3
) (
  input  logic                    clk_p,
  input  logic                    sdram_reset,
  input  logic [NPORT-1:0]        p_stb,
  input  logic [NPORT-1:0]        p_we,
  input  logic [2*NPORT-1:0]      p_sel,
  input  logic [AW*NPORT-1:0]     p_adr,
  input  logic [DATA_W*NPORT-1:0] p_dat,
  output logic [NPORT-1:0]        p_ack,
  output logic [DATA_W-1:0]       p_rdat,
  output logic                    ctrl_rst_n,
  input  logic                    ctrl_ready,
  output logic                    ctrl_wr_req,
  output logic                    ctrl_rd_req,
  input  logic                    ctrl_wr_ack,
  input  logic                    ctrl_rd_ack,
  output logic [1:0]              ctrl_sel,
  output logic [AW:0]             ctrl_adr,
  output logic [DATA_W-1:0]       ctrl_wdat,
  input  logic [DATA_W-1:0]       ctrl_rdat,
  output logic [1:0]              dqm
);

  localparam int unsigned IW = idx_width(NPORT);
  localparam int unsigned CW = 3;
  localparam int unsigned RW = 4;

  if (NPORT < 1 || NPORT > NPORT_MAX) begin : g_nport_check
    $error("sdram_mport: NPORT out of range");
  end

  // Controller reset stretcher
  logic [RW-1:0] rst_cnt;

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      rst_cnt    <= '0;
      ctrl_rst_n <= 1'b0;
    end else if (!ctrl_rst_n) begin
      if (rst_cnt == RW'(RST_DLY - 1)) ctrl_rst_n <= 1'b1;
      else                             rst_cnt    <= rst_cnt + RW'(1);
    end
  end

  logic [NPORT-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  state_t            state, state_d;
  logic [IW-1:0]     g, g_d, ptr, ptr_d, ptr_next;
  logic              we, we_d, ack_r, ack_d, abort, abort_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              wr_req_d, rd_req_d, stb_g, fin;
  logic [1:0]        sel_d, dqm_d, sel_g;
  logic [AW:0]       cadr_d;
  logic [AW-1:0]     adr_g;
  logic [DATA_W-1:0] wdat_d, rdat_d, dat_g;
  logic              we_g;

  sdram_mport_rr_arbiter #(.NPORT(NPORT), .IW(IW)) u_arb (
    .req (p_stb),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot mux of the winning port's payload
  always_comb begin
    sel_g = '0;
    adr_g = '0;
    dat_g = '0;
    we_g  = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (arb_gnt[IW'(i)]) begin
        sel_g = p_sel[2*i +: 2];
        adr_g = p_adr[AW*i +: AW];
        dat_g = p_dat[DATA_W*i +: DATA_W];
        we_g  = p_we[IW'(i)];
      end
    end
  end

  assign ptr_next = (g == IW'(NPORT - 1)) ? '0 : g + IW'(1);

  always_comb begin
    state_d  = state;
    g_d      = g;
    we_d     = we;
    cnt_d    = cnt;
    ack_d    = ack_r;
    abort_d  = abort;
    ptr_d    = ptr;
    rdat_d   = p_rdat;
    wr_req_d = ctrl_wr_req;
    rd_req_d = ctrl_rd_req;
    sel_d    = ctrl_sel;
    cadr_d   = ctrl_adr;
    wdat_d   = ctrl_wdat;
    dqm_d    = dqm;
    fin      = 1'b0;
    stb_g    = p_stb[g];
    case (state)
      ST_IDLE: begin
        if (ctrl_ready && arb_any) begin
          state_d  = ST_REQ;
          g_d      = arb_idx;
          we_d     = we_g;
          sel_d    = sel_g;
          cadr_d   = {1'b0, adr_g};
          wdat_d   = dat_g;
          dqm_d    = we_g ? ~sel_g : 2'b00;
          abort_d  = 1'b0;
          wr_req_d = we_g;
          rd_req_d = !we_g;
        end
      end
      ST_REQ: begin
        if (!stb_g) abort_d = 1'b1;
        if (we ? ctrl_wr_ack : ctrl_rd_ack) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!we) rdat_d = ctrl_rdat;
          if (ACK_DLY <= 1) fin = 1'b1;
          else begin
            state_d = ST_WAIT;
            cnt_d   = CW'(ACK_DLY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!stb_g) abort_d = 1'b1;
        if (cnt <= CW'(1)) fin = 1'b1;
        else               cnt_d = cnt - CW'(1);
      end
      ST_HOLD: begin
        if (!stb_g) begin
          ack_d   = 1'b0;
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An abandoned transaction finishes silently and frees the slot
    if (fin) begin
      if (abort_d) begin
        state_d = ST_IDLE;
        ptr_d   = ptr_next;
      end else begin
        state_d = ST_HOLD;
        ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (sdram_reset) begin
      state       <= ST_IDLE;
      g           <= '0;
      we          <= 1'b0;
      cnt         <= '0;
      ack_r       <= 1'b0;
      abort       <= 1'b0;
      ptr         <= '0;
      p_rdat      <= '0;
      ctrl_wr_req <= 1'b0;
      ctrl_rd_req <= 1'b0;
      ctrl_sel    <= '0;
      ctrl_adr    <= '0;
      ctrl_wdat   <= '0;
      dqm         <= '0;
    end else begin
      state       <= state_d;
      g           <= g_d;
      we          <= we_d;
      cnt         <= cnt_d;
      ack_r       <= ack_d;
      abort       <= abort_d;
      ptr         <= ptr_d;
      p_rdat      <= rdat_d;
      ctrl_wr_req <= wr_req_d;
      ctrl_rd_req <= rd_req_d;
      ctrl_sel    <= sel_d;
      ctrl_adr    <= cadr_d;
      ctrl_wdat   <= wdat_d;
      dqm         <= dqm_d;
    end
  end

  // Ack follows the strobe combinationally so it drops with it
  always_comb begin
    p_ack    = '0;
    p_ack[g] = ack_r & p_stb[g];
  end

endmodule

// File: tb/tb_sdram_mport.sv
// Directed-vector bench for sdram_mport: reset stretcher, single transfers,
// round-robin contention, abort and reset during a request.
module tb_sdram_mport;

  localparam int unsigned NPORT   = 2;
  localparam int unsigned AW      = 21;
  localparam int unsigned ACK_DLY = 2;
  localparam int unsigned RST_DLY = 3;
  localparam int unsigned PW      = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef logic [PW-1:0] pidx_t;

  typedef struct {
    pidx_t        port;
    logic         we;
    logic [1:0]   sel;
    logic [AW-1:0] adr;
    logic [15:0]  dat;
    logic [15:0]  rdat;
    int           k;
    logic [1:0]   exp_dqm;
    logic [AW:0]  exp_cadr;
  } vec_t;

  logic                clk_p = 1'b0;
  logic                sdram_reset;
  logic [NPORT-1:0]    p_stb, p_we, p_ack;
  logic [2*NPORT-1:0]  p_sel;
  logic [AW*NPORT-1:0] p_adr;
  logic [16*NPORT-1:0] p_dat;
  logic [15:0]         p_rdat, ctrl_wdat, ctrl_rdat;
  logic                ctrl_rst_n, ctrl_ready;
  logic                ctrl_wr_req, ctrl_rd_req, ctrl_wr_ack, ctrl_rd_ack;
  logic [1:0]          ctrl_sel, dqm;
  logic [AW:0]         ctrl_adr;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[5];
  vec_t c0, c1, c2, a0, a1, r0, r1;

  always #5 clk_p = ~clk_p;

  sdram_mport #(.NPORT(NPORT), .AW(AW), .ACK_DLY(ACK_DLY), .RST_DLY(RST_DLY)) dut (
    .clk_p       (clk_p),
    .sdram_reset (sdram_reset),
    .p_stb       (p_stb),
    .p_we        (p_we),
    .p_sel       (p_sel),
    .p_adr       (p_adr),
    .p_dat       (p_dat),
    .p_ack       (p_ack),
    .p_rdat      (p_rdat),
    .ctrl_rst_n  (ctrl_rst_n),
    .ctrl_ready  (ctrl_ready),
    .ctrl_wr_req (ctrl_wr_req),
    .ctrl_rd_req (ctrl_rd_req),
    .ctrl_wr_ack (ctrl_wr_ack),
    .ctrl_rd_ack (ctrl_rd_ack),
    .ctrl_sel    (ctrl_sel),
    .ctrl_adr    (ctrl_adr),
    .ctrl_wdat   (ctrl_wdat),
    .ctrl_rdat   (ctrl_rdat),
    .dqm         (dqm)
  );

  function automatic vec_t mk(input int port, input logic we, input logic [1:0] sel,
                              input logic [AW-1:0] adr, input logic [15:0] dat,
                              input logic [15:0] rdat, input int k,
                              input logic [1:0] edqm, input logic [AW:0] ecadr);
    vec_t v;
    v.port = PW'(port); v.we = we; v.sel = sel; v.adr = adr; v.dat = dat;
    v.rdat = rdat; v.k = k; v.exp_dqm = edqm; v.exp_cadr = ecadr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_port(input vec_t v);
    p_we[v.port]              = v.we;
    p_sel[2*v.port +: 2]      = v.sel;
    p_adr[AW*v.port +: AW]    = v.adr;
    p_dat[16*v.port +: 16]    = v.dat;
    p_stb[v.port]             = 1'b1;
  endtask

  // Entered at the negedge of the first request cycle; leaves in the ack cycle.
  task automatic serve(input vec_t v, input string tag);
    check({tag, " req"}, 32'({ctrl_wr_req, ctrl_rd_req}), v.we ? 32'd2 : 32'd1);
    check({tag, " dqm"}, 32'(dqm), 32'(v.exp_dqm));
    check({tag, " sel"}, 32'(ctrl_sel), 32'(v.sel));
    check({tag, " adr"}, 32'(ctrl_adr), 32'(v.exp_cadr));
    if (v.we) check({tag, " wdat"}, 32'(ctrl_wdat), 32'(v.dat));
    for (int c = 1; c < v.k; c++) @(negedge clk_p);
    if (v.we) ctrl_wr_ack = 1'b1;
    else begin
      ctrl_rd_ack = 1'b1;
      ctrl_rdat   = v.rdat;
    end
    @(negedge clk_p);
    ctrl_wr_ack = 1'b0;
    ctrl_rd_ack = 1'b0;
    ctrl_rdat   = 16'hDEAD;
    check({tag, " req drop"}, 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    for (int c = 1; c < int'(ACK_DLY); c++) begin
      check({tag, " early ack"}, 32'(p_ack), 32'd0);
      @(negedge clk_p);
    end
    check({tag, " ack"}, 32'(p_ack), 32'(1) << v.port);
    if (!v.we) check({tag, " rdat"}, 32'(p_rdat), 32'(v.rdat));
  endtask

  task automatic finish_vec(input vec_t v, input string tag);
    p_stb[v.port] = 1'b0;
    #1;
    check({tag, " ack fall"}, 32'(p_ack), 32'd0);
    @(negedge clk_p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sdram_reset = 1'b1;
    ctrl_ready  = 1'b1;
    p_stb = '0; p_we = '0; p_sel = '0; p_adr = '0; p_dat = '0;
    ctrl_wr_ack = 1'b0; ctrl_rd_ack = 1'b0; ctrl_rdat = '0;

    vecs[0] = mk(0, 1'b1, 2'b01, 21'h001234, 16'hBEEF, 16'h0000, 3, 2'b10, 22'h001234);
    vecs[1] = mk(1, 1'b0, 2'b11, 21'h00ABCD, 16'h0000, 16'hA5A5, 2, 2'b00, 22'h00ABCD);
    vecs[2] = mk(0, 1'b0, 2'b10, 21'h1FFFFF, 16'h0000, 16'h5A5A, 1, 2'b00, 22'h1FFFFF);
    vecs[3] = mk(1, 1'b1, 2'b10, 21'h000000, 16'h1234, 16'h0000, 4, 2'b01, 22'h000000);
    vecs[4] = mk(1, 1'b1, 2'b00, 21'h100001, 16'hFFFF, 16'h0000, 1, 2'b11, 22'h100001);
    c0 = mk(0, 1'b1, 2'b11, 21'h000100, 16'h1111, 16'h0000, 1, 2'b00, 22'h000100);
    c1 = mk(1, 1'b1, 2'b11, 21'h000200, 16'h2222, 16'h0000, 1, 2'b00, 22'h000200);
    c2 = mk(0, 1'b0, 2'b01, 21'h000101, 16'h0000, 16'h7777, 2, 2'b00, 22'h000101);
    a0 = mk(0, 1'b1, 2'b11, 21'h002222, 16'hAAAA, 16'h0000, 1, 2'b00, 22'h002222);
    a1 = mk(1, 1'b0, 2'b11, 21'h003333, 16'h0000, 16'h1357, 1, 2'b00, 22'h003333);
    r0 = mk(0, 1'b1, 2'b01, 21'h004444, 16'h5555, 16'h0000, 1, 2'b10, 22'h004444);
    r1 = mk(1, 1'b0, 2'b11, 21'h000042, 16'h0000, 16'h9999, 3, 2'b00, 22'h000042);

    // Reset held 5 cycles with a strobe pending: nothing may move
    drive_port(vecs[0]);
    repeat (5) @(negedge clk_p);
    check("rst p_ack", 32'(p_ack), 32'd0);
    check("rst p_rdat", 32'(p_rdat), 32'd0);
    check("rst ctrl_rst_n", 32'(ctrl_rst_n), 32'd0);
    check("rst req", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    check("rst sel/dqm", 32'({ctrl_sel, dqm}), 32'd0);
    check("rst adr", 32'(ctrl_adr), 32'd0);
    check("rst wdat", 32'(ctrl_wdat), 32'd0);
    p_stb = '0;
    ctrl_ready  = 1'b0;
    sdram_reset = 1'b0;
    for (int c = 1; c <= int'(RST_DLY); c++) begin
      @(negedge clk_p);
      check($sformatf("rst_n release+%0d", c), 32'(ctrl_rst_n), 32'(c == int'(RST_DLY)));
    end

    // No request while the controller is not ready
    drive_port(vecs[0]);
    repeat (3) begin
      @(negedge clk_p);
      check("ready gate", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    end
    ctrl_ready = 1'b1;
    @(negedge clk_p);
    serve(vecs[0], "v0");
    finish_vec(vecs[0], "v0");

    for (int i = 1; i < 5; i++) begin
      drive_port(vecs[i]);
      @(negedge clk_p);
      serve(vecs[i], $sformatf("v%0d", i));
      finish_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Contention: both ports at ptr=0, port 0 re-strobes right after service
    drive_port(c0);
    drive_port(c1);
    @(negedge clk_p);
    serve(c0, "arb p0");
    p_stb[0] = 1'b0;
    #1;
    check("arb p0 ack fall", 32'(p_ack), 32'd0);
    @(negedge clk_p);
    check("arb idle gap", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    drive_port(c2);
    @(negedge clk_p);
    serve(c1, "arb p1 first");
    finish_vec(c1, "arb p1 first");
    @(negedge clk_p);
    serve(c2, "arb p0 again");
    finish_vec(c2, "arb p0 again");

    // Abort: port 0 drops in WAIT while port 1 becomes pending
    drive_port(a0);
    @(negedge clk_p);
    check("abort grant adr", 32'(ctrl_adr), 32'(a0.exp_cadr));
    ctrl_wr_ack = 1'b1;
    @(negedge clk_p);
    ctrl_wr_ack = 1'b0;
    p_stb[0] = 1'b0;
    drive_port(a1);
    #1;
    check("abort wait ack", 32'(p_ack), 32'd0);
    @(negedge clk_p);
    check("abort no ack", 32'(p_ack), 32'd0);
    check("abort idle", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    @(negedge clk_p);
    serve(a1, "abort next");
    finish_vec(a1, "abort next");

    // Reset during REQ
    drive_port(r0);
    @(negedge clk_p);
    check("rstmid req", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd2);
    sdram_reset = 1'b1;
    @(negedge clk_p);
    check("rstmid req drop", 32'({ctrl_wr_req, ctrl_rd_req}), 32'd0);
    check("rstmid ctrl_rst_n", 32'(ctrl_rst_n), 32'd0);
    check("rstmid adr/dqm", 32'({ctrl_adr, dqm}), 32'd0);
    check("rstmid rdat", 32'(p_rdat), 32'd0);
    sdram_reset = 1'b0;
    p_stb       = '0;
    ctrl_ready  = 1'b0;
    repeat (RST_DLY) @(negedge clk_p);
    check("rstmid ctrl_rst_n back", 32'(ctrl_rst_n), 32'd1);
    ctrl_ready = 1'b1;
    drive_port(r1);
    @(negedge clk_p);
    serve(r1, "rstmid fresh");
    finish_vec(r1, "rstmid fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
